program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 16: number of 8-bit instruction words stored.
REQ-002 Parameter DEB_CYCLES, default 16: number of consecutive stable samples needed to accept a button edge.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 Port: sw  input  8  instruction word from board switches; sampled only at the write cycle.
REQ-006 Port: load_btn  input  1  raw, asynchronous, bouncing push-button; a debounced press writes one word.
REQ-007 Port: run_sw  input  1  raw mode switch: 0 = load mode, 1 = run mode.
REQ-008 Port: PC  input  8  program counter from the downstream processor.
REQ-009 Port: instruction  output  8  instruction word presented to the processor.
REQ-010 Port: load_addr  output  4  address the next debounced press will write.
REQ-011 Port: count  output  5  number of valid words loaded (0..DEPTH).
REQ-012 Port: full  output  1  high when count == DEPTH.
REQ-013 Port: running  output  1  high in state RUN only.
REQ-014 Port: write_ack  output  1  one-cycle pulse on the cycle a word is written.

Function
REQ-015 load_btn and run_sw SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized versions (2-cycle input latency).
REQ-016 FSM states SHALL be IDLE, DEBOUNCE, RELEASE and RUN; reset state is IDLE.
REQ-017 IDLE: synced run_sw = 1 -> RUN; else synced button = 1 -> DEBOUNCE with the debounce counter cleared.
REQ-018 DEBOUNCE: counter increments while the button is 1; any 0 sample -> IDLE without writing; counter reaching DEB_CYCLES-1 with the button still 1 -> write and -> RELEASE.
REQ-019 Write: if full = 0, mem[load_addr] <= sw, load_addr increments, count increments, and write_ack pulses in that same cycle; if full = 1, no write, no ack, no pointer change.
REQ-020 RELEASE: transitions to IDLE only after DEB_CYCLES consecutive 0 samples; any 1 sample restarts the count. A held button writes exactly once.
REQ-021 run_sw = 1 during DEBOUNCE or RELEASE SHALL abort to RUN with no write (mode has priority over the press).
REQ-022 RUN: synced run_sw = 0 -> IDLE, clearing load_addr and count to 0; memory contents persist but are masked by count.
REQ-023 instruction SHALL be combinational: in RUN, mem[PC[3:0]] when PC < count, else 8'h00; in every other state, 8'h00.
REQ-024 PC values >= DEPTH SHALL yield 8'h00 (no wrap to low addresses).
REQ-025 load_addr wraps are impossible: it saturates at DEPTH-1 addressing and, once full, no further writes occur.
REQ-026 full SHALL be combinational from count; running SHALL be combinational from state.

Reset
REQ-027 reset low SHALL asynchronously set the state to IDLE; load_addr, count, the debounce counter, the synchronizers, write_ack and all DEPTH memory words to 0; outputs: instruction 8'h00, full 0, running 0.
REQ-028 reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the press; no write occurs on release of reset.
REQ-029 Operation resumes on the first rising clk edge after reset returns high.

Structure
REQ-030 Shared package loader_pkg SHALL hold the state encoding (IDLE, DEBOUNCE, RELEASE, RUN), DEPTH_DEFAULT and the NOP word 8'h00.
REQ-031 One sub-module, btn_debounce (synchronizer, counter, press strobe), SHALL be used; memory and FSM live in program_loader.

Verification
REQ-032 Reset low mid-operation -> all outputs zero within the same cycle; instruction 8'h00 in every state.
REQ-033 sw = 8'hC5, load_btn held 40 cycles with 3-cycle bounces at start -> exactly one write_ack, mem[0] = 8'hC5, count = 1, load_addr = 1.
REQ-034 Load 16 words 8'h10..8'h1F, then a 17th press -> full = 1, count = 16, no write_ack on the 17th press.
REQ-035 Load 3 words, run_sw = 1, PC = 0,1,2,3,200 -> instruction = words 0..2, then 8'h00, 8'h00; running = 1.
REQ-036 Button press in DEBOUNCE, run_sw raised at debounce cycle 5 -> RUN, no write_ack, count unchanged.
REQ-037 RUN -> run_sw = 0 -> count = 0, load_addr = 0, instruction 8'h00; the next press writes address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// memory depth and the word presented to the processor when nothing valid
// is addressed.
package loader_pkg;

    localparam int         DEPTH_DEFAULT = 16;
    localparam logic [7:0] NOP_WORD      = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2,
        RUN      = 2'd3
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchronizer for the raw button plus the
// debounce sample counter. The owning FSM decides when the counter clears
// and advances; this block reports the synchronized level, terminal count
// and a press strobe (button high at terminal count).
//   clk      in   system clock
//   reset    in   async, active-low
//   btn_raw  in   raw bouncing button
//   cnt_clr  in   clear sample counter
//   cnt_inc  in   advance sample counter (holds at terminal count)
//   btn_s    out  synchronized button
//   cnt_tc   out  counter == DEB_CYCLES-1
//   press    out  btn_s & cnt_tc
module btn_debounce
    import loader_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic cnt_clr,
    input  logic cnt_inc,
    output logic btn_s,
    output logic cnt_tc,
    output logic press
);

    localparam int            CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], btn_raw};
        cnt_d  = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != TC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_s  = sync_q[1];
    assign cnt_tc = (cnt_q == TC);
    assign press  = btn_s & cnt_tc;

endmodule

// File: rtl/program_loader.sv
// Loads 8-bit instruction words from board switches into a small memory,
// one word per debounced button press, then serves them to a processor by
// PC while in run mode.
//   clk          in   system clock
//   reset        in   async, active-low
//   sw[7:0]      in   word to store, sampled at the write cycle
//   load_btn     in   raw bouncing load button
//   run_sw       in   raw mode switch (1 = run)
//   PC[7:0]      in   processor program counter
//   instruction  out  mem[PC] when running and PC < count, else NOP
//   load_addr    out  address of the next write
//   count        out  number of valid words
//   full         out  count == DEPTH
//   running      out  FSM in RUN
//   write_ack    out  one-cycle pulse alongside each stored word
//
// state    | meaning
// IDLE     | load mode, waiting for button or run switch
// DEBOUNCE | button seen high, counting stable high samples
// RELEASE  | word written, waiting for stable low before next press
// RUN      | serving instructions to the processor
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       load_btn,
    input  logic       run_sw,
    input  logic [7:0] PC,
    output logic [7:0] instruction,
    output logic [3:0] load_addr,
    output logic [4:0] count,
    output logic       full,
    output logic       running,
    output logic       write_ack
);

    localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    state_e     state_q, state_d;
    logic [3:0] load_addr_q, load_addr_d;
    logic [4:0] count_q, count_d;
    logic       write_ack_q, write_ack_d;
    logic [1:0] run_sync_q, run_sync_d;
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    logic run_s, btn_s, cnt_tc, press, cnt_clr, cnt_inc;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (load_btn),
        .cnt_clr (cnt_clr),
        .cnt_inc (cnt_inc),
        .btn_s   (btn_s),
        .cnt_tc  (cnt_tc),
        .press   (press)
    );

    assign run_sync_d = {run_sync_q[0], run_sw};
    assign run_s      = run_sync_q[1];

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        count_d     = count_q;
        write_ack_d = 1'b0;
        mem_d       = mem_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        // Mode switch outranks any press in progress.
        case (state_q)
            IDLE: begin
                if (run_s) begin
                    state_d = RUN;
                end else if (btn_s) begin
                    state_d = DEBOUNCE;
                    cnt_clr = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (run_s) begin
                    state_d = RUN;
                end else if (!btn_s) begin
                    state_d = IDLE;
                end else if (press) begin
                    state_d = RELEASE;
                    cnt_clr = 1'b1;
                    if (count_q != DEPTH_C) begin
                        mem_d[load_addr_q] = sw;
                        count_d            = count_q + 1'b1;
                        write_ack_d        = 1'b1;
                        // Pointer parks on the last word; count alone marks full.
                        if (load_addr_q != LAST_ADDR) begin
                            load_addr_d = load_addr_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RELEASE: begin
                if (run_s) begin
                    state_d = RUN;
                end else if (btn_s) begin
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_d     = IDLE;
                    load_addr_d = '0;
                    count_d     = '0;
                    cnt_clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            load_addr_q <= '0;
            count_q     <= '0;
            write_ack_q <= 1'b0;
            run_sync_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            count_q     <= count_d;
            write_ack_q <= write_ack_d;
            run_sync_q  <= run_sync_d;
            mem_q       <= mem_d;
        end
    end

    // Full 8-bit compare against count so PCs beyond the memory never alias.
    always_comb begin
        instruction = NOP_WORD;
        if ((state_q == RUN) && ({3'b000, count_q} > PC)) begin
            instruction = mem_q[PC[3:0]];
        end
    end

    assign load_addr = load_addr_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign running   = (state_q == RUN);
    assign write_ack = write_ack_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       load_btn = 1'b0;
    logic       run_sw = 1'b0;
    logic [7:0] PC = 8'h00;
    logic [7:0] instruction;
    logic [3:0] load_addr;
    logic [4:0] count;
    logic       full;
    logic       running;
    logic       write_ack;

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .load_btn    (load_btn),
        .run_sw      (run_sw),
        .PC          (PC),
        .instruction (instruction),
        .load_addr   (load_addr),
        .count       (count),
        .full        (full),
        .running     (running),
        .write_ack   (write_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    // Reference model: list of stored words and how many are valid.
    logic [7:0] mmem [16];
    int         mcount = 0;

    always @(negedge clk) begin
        if (write_ack) ack_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] model_instr(input int p);
        if (p < mcount) return mmem[p];
        return 8'h00;
    endfunction

    function automatic logic [3:0] model_addr();
        if (mcount > 15) return 4'd15;
        return 4'(mcount);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
        mcount = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_instr"}, instruction, 8'h00);
        check_val({tag, "_addr"}, load_addr, 4'd0);
        check_val({tag, "_count"}, count, 5'd0);
        check_val({tag, "_full"}, full, 1'b0);
        check_val({tag, "_running"}, running, 1'b0);
        check_val({tag, "_ack"}, write_ack, 1'b0);
    endtask

    // nb bounces of length blen (0 = random 1..5) at press and at release.
    task automatic press(input logic [7:0] val, input int nb, input int blen);
        int a0;
        int exp_ack;
        int l;
        sw = val;
        a0 = ack_cnt;
        for (int i = 0; i < nb; i++) begin
            l = (blen > 0) ? blen : int'($urandom_range(1, 5));
            load_btn = 1'b1; tick(l);
            load_btn = 1'b0; tick(l);
        end
        load_btn = 1'b1; tick(40);
        for (int i = 0; i < nb; i++) begin
            l = (blen > 0) ? blen : int'($urandom_range(1, 5));
            load_btn = 1'b0; tick(l);
            load_btn = 1'b1; tick(l);
        end
        load_btn = 1'b0; tick(40);
        sw = 8'($urandom);

        exp_ack = (mcount < 16) ? 1 : 0;
        if (exp_ack == 1) begin
            mmem[mcount] = val;
            mcount++;
        end
        check_val("press_ack", ack_cnt - a0, exp_ack);
        check_val("press_count", count, mcount);
        check_val("press_addr", load_addr, model_addr());
        check_val("press_full", full, (mcount == 16));
        PC = 8'h00; #1;
        check_val("load_instr_nop", instruction, 8'h00);
    endtask

    task automatic run_phase(input int nrand);
        int p;
        run_sw = 1'b1; tick(4);
        check_val("run_running", running, 1'b1);
        for (int i = 0; i < 18 + nrand; i++) begin
            p = (i < 18) ? i : int'($urandom_range(0, 255));
            PC = 8'(p); #1;
            check_val($sformatf("instr_pc%0d", p), instruction, model_instr(p));
        end
        PC = 8'd200; #1;
        check_val("instr_pc200", instruction, 8'h00);
        PC = 8'd255; #1;
        check_val("instr_pc255", instruction, 8'h00);
        PC = 8'h00;
        run_sw = 1'b0; tick(4);
        mcount = 0;
        check_val("exit_running", running, 1'b0);
        check_val("exit_count", count, 5'd0);
        check_val("exit_addr", load_addr, 4'd0);
        check_val("exit_instr", instruction, 8'h00);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        model_clear();
        #3;
        check_reset_outputs("por");
        tick(2);
        reset = 1'b1;
        tick(3);
        check_reset_outputs("post_reset");

        // Bounced press with a fixed word.
        press(8'hC5, 3, 3);
        run_phase(2);

        // Three random words.
        for (int i = 0; i < 3; i++) press(8'($urandom), int'($urandom_range(0, 2)), 0);
        run_phase(3);

        // Fill to depth, then one more press that must be ignored.
        for (int i = 0; i < 16; i++) press(8'(8'h10 + i), int'($urandom_range(0, 2)), 0);
        press(8'h99, 1, 0);
        run_phase(4);

        // Mode switch raised mid-debounce aborts the press.
        press(8'($urandom), 0, 0);
        a0 = ack_cnt;
        sw = 8'hEE;
        load_btn = 1'b1; tick(8);
        run_sw = 1'b1; tick(25);
        check_val("abort_running", running, 1'b1);
        check_val("abort_no_ack", ack_cnt - a0, 0);
        check_val("abort_count", count, mcount);
        PC = 8'h00; #1;
        check_val("abort_instr0", instruction, model_instr(0));
        PC = 8'h01; #1;
        check_val("abort_instr1", instruction, 8'h00);
        load_btn = 1'b0; tick(10);
        run_sw = 1'b0; tick(4);
        mcount = 0;
        check_val("abort_exit_count", count, 5'd0);
        check_val("abort_exit_addr", load_addr, 4'd0);
        press(8'h5A, 1, 0);
        run_phase(1);

        // Reset during a press discards it.
        press(8'($urandom), 0, 0);
        press(8'($urandom), 0, 0);
        a0 = ack_cnt;
        load_btn = 1'b1; tick(8);
        reset = 1'b0; #1;
        check_reset_outputs("rst_debounce");
        load_btn = 1'b0; tick(3);
        reset = 1'b1; tick(40);
        model_clear();
        check_val("rst_debounce_no_ack", ack_cnt - a0, 0);
        check_val("rst_debounce_count", count, 5'd0);

        // Reset while running.
        press(8'($urandom_range(1, 255)), 0, 0);
        press(8'($urandom), 0, 0);
        run_sw = 1'b1; tick(4);
        PC = 8'h00; #1;
        check_val("rst_run_pre_instr", instruction, model_instr(0));
        reset = 1'b0; #1;
        check_reset_outputs("rst_run");
        run_sw = 1'b0; tick(2);
        reset = 1'b1; tick(5);
        model_clear();
        run_phase(1);

        // Random sessions.
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) press(8'($urandom), int'($urandom_range(0, 3)), 0);
            run_phase(3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
